// File: rtl/fft_buf_ctrl.sv
// Ping-pong buffer controller: FFT stream fills one RAM bank while Wishbone reads the other.
// Optional FFT_BUF_DROP_CNT_EN adds a saturating 16-bit dropped-frame counter output.
module fft_buf_ctrl #(
  parameter int Add_WordWidth  = 9,
  parameter int Data_WordWidth = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      fft_valid,
  input  logic [Data_WordWidth-1:0] fft_dat,
  input  logic                      wb_cyc,
  input  logic                      wb_stb,
  input  logic [Add_WordWidth-1:0]  wb_adr,
  output logic                      wb_ack,
  input  logic                      rel,
  output logic                      frame_rdy,
  output logic                      ovf,
  output logic                      ram_we,
  output logic [Add_WordWidth:0]    ram_adr_wr,
  output logic [Data_WordWidth-1:0] ram_dat_w,
  output logic [Add_WordWidth:0]    ram_adr_rd
`ifdef FFT_BUF_DROP_CNT_EN
  ,
  output logic [15:0]               drop_cnt
`endif
);

  typedef enum logic {ST_FILL, ST_DROP} wr_state_e;

  wr_state_e                 state_q, state_d;
  logic [Add_WordWidth-1:0]  wr_cnt_q, wr_cnt_d;
  logic                      fill_bank_q, fill_bank_d;
  logic                      rd_bank_q, rd_bank_d;
  logic [1:0]                full_q, full_d;
  logic                      set_pend_q, set_pend_d;
  logic                      set_bank_q, set_bank_d;
  logic                      ovf_q, ovf_d;
  logic                      wb_ack_q, wb_ack_d;
  logic                      ram_we_q, ram_we_d;
  logic [Add_WordWidth:0]    ram_adr_wr_q, ram_adr_wr_d;
  logic [Data_WordWidth-1:0] ram_dat_w_q, ram_dat_w_d;
`ifdef FFT_BUF_DROP_CNT_EN
  logic [15:0]               drop_cnt_q, drop_cnt_d;
`endif

  logic last_word;
  assign last_word = (wr_cnt_q == '1);

  always_comb begin
    state_d      = state_q;
    wr_cnt_d     = wr_cnt_q;
    fill_bank_d  = fill_bank_q;
    rd_bank_d    = rd_bank_q;
    full_d       = full_q;
    set_pend_d   = 1'b0;
    set_bank_d   = set_bank_q;
    ovf_d        = ovf_q;
    ram_we_d     = 1'b0;
    ram_adr_wr_d = ram_adr_wr_q;
    ram_dat_w_d  = ram_dat_w_q;
    wb_ack_d     = wb_cyc & wb_stb & ~wb_ack_q;
`ifdef FFT_BUF_DROP_CNT_EN
    drop_cnt_d   = drop_cnt_q;
`endif

    // Full-set is delayed one cycle so it lands on the edge that writes the last word.
    if (set_pend_q)
      full_d[set_bank_q] = 1'b1;
    if (rel && full_q[rd_bank_q]) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end

    unique case (state_q)
      ST_FILL: begin
        if (fft_valid) begin
          wr_cnt_d = wr_cnt_q + 1'b1;
          if (wr_cnt_q == '0 && full_q[fill_bank_q]) begin
            state_d = ST_DROP;
            ovf_d   = 1'b1;
`ifdef FFT_BUF_DROP_CNT_EN
            if (drop_cnt_q != '1)
              drop_cnt_d = drop_cnt_q + 16'd1;
`endif
          end else begin
            ram_we_d     = 1'b1;
            ram_adr_wr_d = {fill_bank_q, wr_cnt_q};
            ram_dat_w_d  = fft_dat;
            if (last_word) begin
              fill_bank_d = ~fill_bank_q;
              set_pend_d  = 1'b1;
              set_bank_d  = fill_bank_q;
            end
          end
        end
      end
      ST_DROP: begin
        if (fft_valid) begin
          wr_cnt_d = wr_cnt_q + 1'b1;
          if (last_word)
            state_d = ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_FILL;
      wr_cnt_q     <= '0;
      fill_bank_q  <= 1'b0;
      rd_bank_q    <= 1'b0;
      full_q       <= '0;
      set_pend_q   <= 1'b0;
      set_bank_q   <= 1'b0;
      ovf_q        <= 1'b0;
      wb_ack_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_adr_wr_q <= '0;
      ram_dat_w_q  <= '0;
`ifdef FFT_BUF_DROP_CNT_EN
      drop_cnt_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      wr_cnt_q     <= wr_cnt_d;
      fill_bank_q  <= fill_bank_d;
      rd_bank_q    <= rd_bank_d;
      full_q       <= full_d;
      set_pend_q   <= set_pend_d;
      set_bank_q   <= set_bank_d;
      ovf_q        <= ovf_d;
      wb_ack_q     <= wb_ack_d;
      ram_we_q     <= ram_we_d;
      ram_adr_wr_q <= ram_adr_wr_d;
      ram_dat_w_q  <= ram_dat_w_d;
`ifdef FFT_BUF_DROP_CNT_EN
      drop_cnt_q   <= drop_cnt_d;
`endif
    end
  end

  assign wb_ack     = wb_ack_q;
  assign frame_rdy  = full_q[rd_bank_q];
  assign ovf        = ovf_q;
  assign ram_we     = ram_we_q;
  assign ram_adr_wr = ram_adr_wr_q;
  assign ram_dat_w  = ram_dat_w_q;
  assign ram_adr_rd = {rd_bank_q, wb_adr};
`ifdef FFT_BUF_DROP_CNT_EN
  assign drop_cnt   = drop_cnt_q;
`endif

endmodule

// File: tb/tb_fft_buf_ctrl.sv
// Scoreboard bench for fft_buf_ctrl with a frame-level reference model and a behavioural RAM.
module tb_fft_buf_ctrl;
  localparam int AW = 2;
  localparam int DW = 32;
  localparam int N  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          fft_valid;
  logic [DW-1:0] fft_dat;
  logic          wb_cyc, wb_stb;
  logic [AW-1:0] wb_adr;
  logic          wb_ack;
  logic          rel;
  logic          frame_rdy, ovf, ram_we;
  logic [AW:0]   ram_adr_wr, ram_adr_rd;
  logic [DW-1:0] ram_dat_w;
`ifdef FFT_BUF_DROP_CNT_EN
  logic [15:0]   drop_cnt;
`endif

  fft_buf_ctrl #(.Add_WordWidth(AW), .Data_WordWidth(DW)) dut (
    .clk(clk), .rst(rst), .fft_valid(fft_valid), .fft_dat(fft_dat),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_adr(wb_adr), .wb_ack(wb_ack),
    .rel(rel), .frame_rdy(frame_rdy), .ovf(ovf), .ram_we(ram_we),
    .ram_adr_wr(ram_adr_wr), .ram_dat_w(ram_dat_w), .ram_adr_rd(ram_adr_rd)
`ifdef FFT_BUF_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Dual-address RAM attached to the controller
  logic [DW-1:0] mem [0:2*N-1];
  logic [DW-1:0] rdata;
  always @(posedge clk) begin
    if (ram_we) mem[ram_adr_wr] <= ram_dat_w;
    rdata <= mem[ram_adr_rd];
  end

  // Reference model state: banks as a two-entry ring, frames counted in samples
  int            m_fill, m_rd, m_cnt, m_drops;
  bit            m_drop, m_ovf;
  bit            m_full [2];
  logic [DW-1:0] m_mem [0:2*N-1];

  logic [DW+AW:0] wq[$];
  logic [DW-1:0]  rq[$];
  int total = 0;
  int bad   = 0;
  logic ack_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ram_we === 1'b1) begin
      if (wq.size() == 0) check("unexpected_write", {ram_adr_wr, ram_dat_w}, '0);
      else check("ram_write", {ram_adr_wr, ram_dat_w}, wq.pop_front());
    end
    if (wb_ack === 1'b1) begin
      check("ack_not_consecutive", ack_prev, 1'b0);
      if (rq.size() == 0) check("unexpected_ack", 1'b1, 1'b0);
      else check("wb_read", rdata, rq.pop_front());
    end
    ack_prev = wb_ack;
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic model_reset;
    m_fill = 0; m_rd = 0; m_cnt = 0; m_drop = 0; m_ovf = 0; m_drops = 0;
    m_full[0] = 0; m_full[1] = 0;
  endtask

  task automatic send(input logic [DW-1:0] d);
    if (m_cnt == 0 && !m_drop && m_full[m_fill]) begin
      m_drop = 1; m_ovf = 1; m_drops++;
    end
    if (!m_drop) begin
      wq.push_back({3'(m_fill * N + m_cnt), d});
      m_mem[m_fill * N + m_cnt] = d;
    end
    m_cnt++;
    if (m_cnt == N) begin
      m_cnt = 0;
      if (m_drop) m_drop = 0;
      else begin m_full[m_fill] = 1; m_fill ^= 1; end
    end
    fft_valid = 1'b1; fft_dat = d;
    tick;
    fft_valid = 1'b0; fft_dat = $urandom;
  endtask

  task automatic send_frame(input logic [DW-1:0] base, input bit gaps);
    for (int i = 0; i < N; i++) begin
      send(base + DW'(i));
      if (gaps) repeat ($urandom_range(0, 2)) tick;
    end
  endtask

  task automatic settle;
    repeat (3) tick;
    check("frame_rdy", frame_rdy, m_full[m_rd]);
    check("ovf", ovf, m_ovf);
`ifdef FFT_BUF_DROP_CNT_EN
    check("drop_cnt", drop_cnt, 64'(m_drops));
`endif
    check("writes_drained", wq.size(), 0);
  endtask

  task automatic rd(input int a);
    rq.push_back(m_mem[m_rd * N + a]);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_adr = AW'(a);
    tick;
    tick;
    wb_cyc = 1'b0; wb_stb = 1'b0;
    tick;
    check("read_acked", rq.size(), 0);
  endtask

  task automatic rel_pulse;
    if (m_full[m_rd]) begin m_full[m_rd] = 0; m_rd ^= 1; end
    rel = 1'b1;
    tick;
    rel = 1'b0;
    check("frame_rdy_after_rel", frame_rdy, m_full[m_rd]);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    wq.delete(); rq.delete();
    model_reset();
    #1;
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_adr_wr", ram_adr_wr, 0);
    check("rst_ram_dat_w", ram_dat_w, 0);
    check("rst_wb_ack", wb_ack, 0);
    check("rst_frame_rdy", frame_rdy, 0);
    check("rst_ovf", ovf, 0);
`ifdef FFT_BUF_DROP_CNT_EN
    check("rst_drop_cnt", drop_cnt, 0);
`endif
    tick;
    rst = 1'b0;
    tick;
  endtask

  initial begin
    rst = 1'b1; fft_valid = 0; fft_dat = '0; wb_cyc = 0; wb_stb = 0; wb_adr = '0; rel = 0;
    model_reset();
    tick;
    do_reset();

    // First frame: frame_rdy appears two cycles after the last sample
    send(32'h10); send(32'h11); send(32'h12); send(32'h13);
    check("frame_rdy_t1", frame_rdy, 0);
    tick;
    check("frame_rdy_t2", frame_rdy, 1);
    settle();
    for (int a = 0; a < N; a++) rd(a);

    // Second frame into bank 1, then release bank 0
    send_frame(32'h20, 0);
    settle();
    rel_pulse();
    for (int a = 0; a < N; a++) rd(a);

    // Fill bank 0, then a frame with both banks full is dropped
    send_frame(32'h30, 1);
    settle();
    send_frame(32'h40, 0);
    settle();
    rel_pulse();
    send_frame(32'h50, 0);
    settle();
    for (int a = 0; a < N; a++) rd(a);

    // Mid-frame reset, then back-to-back frames from address 0
    send(32'h60); send(32'h61);
    do_reset();
    send_frame(32'h70, 0);
    send_frame(32'h80, 0);
    settle();
    for (int a = 0; a < N; a++) rd(a);
    rel_pulse();
    rel_pulse();
    rel_pulse();
    settle();

    // rel with nothing ready leaves the read bank unchanged
    send_frame(32'h90, 0);
    settle();
    rd(0); rd(3);

    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 3))
        0: begin send_frame($urandom, 1); settle(); end
        1: rel_pulse();
        2: if (m_full[m_rd]) begin
             rd(int'($urandom_range(0, N - 1)));
             rd(int'($urandom_range(0, N - 1)));
           end
        default: begin send_frame($urandom, 0); send_frame($urandom, 0); settle(); end
      endcase
    end
    settle();
    check("reads_drained", rq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fft_buf_ctrl.md
# fft_buf_ctrl

Ping-pong buffer controller between the streaming FFT output and the Wishbone read side of the shared dual-address RAM. It splits the RAM into two banks and fills one bank from the FFT sample stream while the host reads the other over Wishbone. It drives the RAM write address, write enable and write data, and the RAM read address, and generates the Wishbone acknowledge. Frames that arrive while both banks are full are dropped whole and flagged.

## Interface
- Add_WordWidth, 9, log2 of words per bank; RAM is 2^(Add_WordWidth+1) words
- Data_WordWidth, 32, sample/data word width
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- fft_valid  in  1  FFT sample strobe; no backpressure, one sample per asserted cycle
- fft_dat  in  Data_WordWidth  FFT sample
- wb_cyc, wb_stb  in  1  Wishbone cycle/strobe (read only; WE ignored)
- wb_adr  in  Add_WordWidth  word address within the readable bank
- wb_ack  out  1  Wishbone acknowledge
- rel  in  1  one-cycle pulse: host finished with current bank
- frame_rdy  out  1  readable bank holds a complete frame
- ovf  out  1  sticky: at least one frame dropped; cleared only by rst
- ram_we  out  1  RAM write enable
- ram_adr_wr  out  Add_WordWidth+1  RAM write address {fill_bank, wr_cnt}
- ram_dat_w  out  Data_WordWidth  RAM write data
- ram_adr_rd  out  Add_WordWidth+1  RAM read address {rd_bank, wb_adr}, combinational

## Operation
- State: fill_bank, rd_bank (1 bit each), full[1:0], wr_cnt (Add_WordWidth bits), write FSM {FILL, DROP}.
- FILL, fft_valid, wr_cnt==0, full[fill_bank]==1: enter DROP, sample discarded, set ovf.
- FILL, fft_valid otherwise: register ram_we=1, ram_adr_wr={fill_bank,wr_cnt}, ram_dat_w=fft_dat; wr_cnt+1. On wr_cnt==2^Add_WordWidth-1: wr_cnt wraps to 0, fill_bank toggles, full-set of the completed bank scheduled (see Timing).
- DROP: each fft_valid increments wr_cnt, no RAM write; on wrap to 0 return to FILL. Frame alignment is held by wr_cnt in both states.
- frame_rdy = full[rd_bank].
- rel while frame_rdy: clear full[rd_bank], toggle rd_bank. rel while !frame_rdy: ignored.
- Same-cycle set and clear never hit the same bank (set only on an empty bank, clear only on a full one); both take effect.
- Wishbone: wb_ack <= wb_cyc & wb_stb & ~wb_ack. Every access takes 2 cycles; reads with !frame_rdy are still acked, data undefined.

## Timing
- Reset values: wb_ack=0, ram_we=0, ram_adr_wr=0, ram_dat_w=0, frame_rdy=0, ovf=0; fill_bank=rd_bank=0, full=00, wr_cnt=0, FSM=FILL.
- Sample at cycle t -> ram_we high in cycle t+1 -> RAM written at edge ending t+1.
- Last sample of frame at cycle t: full bit set at the same edge the last word is written; frame_rdy high from cycle t+2. Reads from t+2 on see the complete frame.
- Read: strobe in cycle t -> RAM samples ram_adr_rd at edge ending t -> wb_ack and valid RAM data in cycle t+1.
- Bank toggles in the cycle after the last sample; a following sample in that cycle goes to the new bank at address 0.
- rel effect visible in the next cycle: frame_rdy reflects the new rd_bank.
- rst mid-frame: all state to reset values immediately; partial frame lost, ovf cleared.

## Configuration
- FFT_BUF_DROP_CNT_EN defined: adds output drop_cnt (16 bits), incremented once per dropped frame on entry to DROP, saturates at 0xFFFF, reset to 0.
- Undefined: no drop_cnt port or logic; ovf behaviour unchanged.

## Test plan
- Add_WordWidth=2: 4 samples 0x10..0x13 -> writes at 0..3, frame_rdy rises 2 cycles after last fft_valid; Wishbone reads adr 0..3 return 0x10..0x13, ack one cycle after each strobe, never two consecutive cycles.
- Second frame 0x20..0x23 with no rel -> writes at 4..7; rel -> frame_rdy stays 1, reads return 0x20..0x23.
- Third frame while both banks full -> no ram_we, ovf=1, drop_cnt=1 (macro on); after rel, fourth frame writes to bank 0.
- Back-to-back frames with fft_valid every cycle -> 8 consecutive writes, addresses 0..7, no gap at the bank toggle.
- rel with frame_rdy=0 -> no change to rd_bank or full.
- rst asserted after 2 samples of a frame -> outputs at reset values; next frame writes from address 0.
